alu_rsv_station: RTL and testbench
==================================

# alu_rsv_station

Reservation station directly upstream of the integer `alu`. It buffers up to `DEPTH` dispatched ALU ops and captures missing source operands from the common data bus (CDB) by tag. Each cycle it issues the oldest entry whose operands are both present, presenting `i_A`/`i_B`/`i_Control`-ready values to the ALU stage.

## Interface
- `DEPTH`, 4: number of entries (2..16)
- `TAG_W`, 4: physical/ROB tag width
- `D_WIDTH`, from `param.v` (32): operand width
- `i_clk` in 1: clock
- `i_rst_n` in 1: asynchronous, active-low reset
- `i_flush` in 1: synchronous flush of all entries
- `i_disp_valid` in 1: dispatch request
- `o_disp_ready` out 1: entry free
- `i_disp_ctrl` in 2: ALU op (00 A+B, 01 A−B, 10 pass B, 11 pass A)
- `i_disp_dst_tag` in TAG_W: result tag
- `i_disp_a_rdy`, `i_disp_b_rdy` in 1 each: operand already valid
- `i_disp_a_val`, `i_disp_b_val` in D_WIDTH each: operand value when ready
- `i_disp_a_tag`, `i_disp_b_tag` in TAG_W each: producer tag when not ready
- `i_cdb_valid` in 1; `i_cdb_tag` in TAG_W; `i_cdb_data` in D_WIDTH: result broadcast
- `o_iss_valid` out 1; `i_iss_ready` in 1: issue handshake
- `o_iss_ctrl` out 2; `o_iss_a`, `o_iss_b` out D_WIDTH; `o_iss_dst_tag` out TAG_W: issued op
- `o_count` out clog2(DEPTH+1): occupied entries

## Operation
- Entry fields: valid, ctrl, dst_tag, per-operand {rdy, tag, val}.
- Dispatch accepted on `i_disp_valid && o_disp_ready`. The op is written to the lowest-index free entry. `o_disp_ready = (o_count < DEPTH)`. It does not depend on a same-cycle issue, so there is no fill-on-free.
- Dispatch-cycle capture (always present): a not-ready operand whose tag equals `i_cdb_tag` while `i_cdb_valid` is high is written rdy=1 with `i_cdb_data`.
- Wakeup: every valid entry with a not-ready operand matching the CDB tag sets rdy and latches the data. Both operands may match in the same cycle.
- Age is tracked in a DEPTH×DEPTH age matrix. On dispatch to entry k, row k is set to the current valid vector (k is younger than all existing entries) and column k is cleared.
- Select: entry ready = valid && a.rdy && b.rdy. The oldest ready entry is the one with no older ready entry.
- `o_iss_*` are combinational from the selected entry. `o_iss_valid` is 1 iff any entry is ready.
- The selected entry is freed on `o_iss_valid && i_iss_ready`. If `i_iss_ready` is low, the selection holds stable unless an older entry becomes ready.
- `o_count` next = count + accept − issue.
- Flush: all valid bits are cleared next edge and `o_count` becomes 0. Flush has priority over dispatch (the dispatched op is dropped), wakeup and issue. `o_iss_valid` may still be 1 in the flush cycle; the consumer ignores it.
- Reset (async, `i_rst_n`=0): all valid bits 0, age matrix 0, `o_count`=0, `o_iss_valid`=0, `o_disp_ready`=1. Other `o_iss_*` are don't-care but driven to 0. Reset mid-operation discards all entries.
- Width rules: values are stored unmodified. No arithmetic is performed here. Flags are produced by the ALU.

## Timing
- Dispatch with both operands ready at edge t: `o_iss_valid` is high in cycle t+1.
- Entry waiting on a tag, broadcast in cycle t: issuable at t+1 (see Configuration for t).
- Issue accepted in cycle t: the entry is free and `o_disp_ready` reflects it from t+1.
- Full with simultaneous issue: dispatch is still refused that cycle.

## Configuration
- `ALU_RS_WAKEUP_BYPASS_EN`
  - Defined: an entry whose last missing operand matches the CDB in cycle t counts as ready in cycle t. The matching `o_iss_a`/`o_iss_b` is forwarded from `i_cdb_data`, giving back-to-back dependent issue.
  - Undefined: readiness comes only from registered rdy bits, adding 1 cycle of wakeup latency.
  - Dispatch-cycle capture is unaffected either way. A newly dispatched op never issues in its dispatch cycle.

## Structure
- Shared package/include (alongside `param.v`):
  - ALU op encodings `ALU_ADD`=2'b00, `ALU_SUB`=2'b01, `ALU_PASSB`=2'b10, `ALU_PASSA`=2'b11
  - `TAG_W` default
  - entry-field widths
- Sub-module `alu_rs_oldest_sel`: takes the ready vector and age matrix, outputs a one-hot grant and a found flag. It is purely combinational and parameterised by `DEPTH`.

## Test plan
- Reset, then dispatch ADD with A=5, B=7 (both ready), dst tag 3 → next cycle `o_iss_valid`=1, ctrl 00, A=5, B=7, tag 3; after accept `o_count`=0.
- Dispatch SUB with A waiting on tag 9; CDB broadcasts tag 9, data 0x10, two cycles later → issue A=0x10 one cycle after the broadcast (same cycle with the macro).
- Dispatch an op with A tag 4 while the CDB broadcasts tag 4 = 0xFF in that same cycle → entry captured ready; issues next cycle with A=0xFF.
- Fill 4 entries with `i_iss_ready`=0 → `o_disp_ready`=0 and `o_count`=4. Make all ready and hold `i_iss_ready`=1 → issue order matches dispatch order over 4 consecutive cycles.
- Entries 0 (older) and 1 (younger) waiting on tags 2 and 1. Broadcast tag 1, then tag 2 → entry 1 issues first; once both are ready, the older wins.
- Three entries valid, assert `i_flush` together with `i_disp_valid` → next cycle `o_count`=0 and `o_iss_valid`=0. Assert `i_rst_n`=0 mid-stream → outputs go to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_rsv_station_pkg.sv
// alu_rsv_station_pkg: ALU op encodings and default field widths shared by the reservation station
package alu_rsv_station_pkg;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_PASSB = 2'b10;
  localparam logic [1:0] ALU_PASSA = 2'b11;
  localparam int CTRL_W      = 2;
  localparam int TAG_W_DEF   = 4;
  localparam int D_WIDTH_DEF = 32;
endpackage

// File: rtl/alu_rs_oldest_sel.sv
// alu_rs_oldest_sel: one-hot grant of the oldest ready entry from an age matrix (row k = entries older than k)
module alu_rs_oldest_sel #(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0]            ready,
  input  logic [DEPTH-1:0][DEPTH-1:0] age,
  output logic [DEPTH-1:0]            grant,
  output logic                        found
);
  // an entry wins when no entry older than it is also ready
  always_comb begin
    for (int k = 0; k < DEPTH; k++) grant[k] = ready[k] && !(|(age[k] & ready));
  end
  assign found = |grant;
endmodule

// File: rtl/alu_rsv_station.sv
// alu_rsv_station: ALU reservation station with CDB wakeup and oldest-ready issue.
// Optional ALU_RS_WAKEUP_BYPASS_EN: an entry completed by the current CDB broadcast issues in the same cycle.
module alu_rsv_station
  import alu_rsv_station_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int D_WIDTH = D_WIDTH_DEF
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_flush,
  input  logic                         i_disp_valid,
  output logic                         o_disp_ready,
  input  logic [CTRL_W-1:0]            i_disp_ctrl,
  input  logic [TAG_W-1:0]             i_disp_dst_tag,
  input  logic                         i_disp_a_rdy,
  input  logic                         i_disp_b_rdy,
  input  logic [D_WIDTH-1:0]           i_disp_a_val,
  input  logic [D_WIDTH-1:0]           i_disp_b_val,
  input  logic [TAG_W-1:0]             i_disp_a_tag,
  input  logic [TAG_W-1:0]             i_disp_b_tag,
  input  logic                         i_cdb_valid,
  input  logic [TAG_W-1:0]             i_cdb_tag,
  input  logic [D_WIDTH-1:0]           i_cdb_data,
  output logic                         o_iss_valid,
  input  logic                         i_iss_ready,
  output logic [CTRL_W-1:0]            o_iss_ctrl,
  output logic [D_WIDTH-1:0]           o_iss_a,
  output logic [D_WIDTH-1:0]           o_iss_b,
  output logic [TAG_W-1:0]             o_iss_dst_tag,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]            valid, a_rdy, b_rdy, a_hit, b_hit, a_ok, b_ok, ready, grant, free_oh;
  logic [DEPTH-1:0][DEPTH-1:0] age, age_nxt;
  logic [CTRL_W-1:0]           ctrl    [DEPTH];
  logic [TAG_W-1:0]            dst_tag [DEPTH];
  logic [TAG_W-1:0]            a_tag   [DEPTH];
  logic [TAG_W-1:0]            b_tag   [DEPTH];
  logic [D_WIDTH-1:0]          a_val   [DEPTH];
  logic [D_WIDTH-1:0]          b_val   [DEPTH];
  logic [CNT_W-1:0]            count;
  logic                        accept, fire, found, disp_a_hit, disp_b_hit;

  assign o_count      = count;
  assign o_disp_ready = count < CNT_W'(DEPTH);
  assign accept       = i_disp_valid && o_disp_ready;
  assign fire         = found && i_iss_ready;
  assign o_iss_valid  = found;
  assign free_oh      = ~valid & (valid + DEPTH'(1));
  assign disp_a_hit   = !i_disp_a_rdy && i_cdb_valid && (i_disp_a_tag == i_cdb_tag);
  assign disp_b_hit   = !i_disp_b_rdy && i_cdb_valid && (i_disp_b_tag == i_cdb_tag);

  // CDB tag match per stored operand, and the effective readiness used for select
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      a_hit[k] = i_cdb_valid && (a_tag[k] == i_cdb_tag);
      b_hit[k] = i_cdb_valid && (b_tag[k] == i_cdb_tag);
    end
`ifdef ALU_RS_WAKEUP_BYPASS_EN
    a_ok = a_rdy | a_hit;
    b_ok = b_rdy | b_hit;
`else
    a_ok = a_rdy;
    b_ok = b_rdy;
`endif
    ready = valid & a_ok & b_ok;
  end

  alu_rs_oldest_sel #(.DEPTH(DEPTH)) u_sel (
    .ready (ready),
    .age   (age),
    .grant (grant),
    .found (found)
  );

  // issue mux from the granted entry; operands not yet latched are forwarded from the CDB
  always_comb begin
    o_iss_ctrl    = '0;
    o_iss_a       = '0;
    o_iss_b       = '0;
    o_iss_dst_tag = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (grant[k]) begin
        o_iss_ctrl    = ctrl[k];
        o_iss_dst_tag = dst_tag[k];
`ifdef ALU_RS_WAKEUP_BYPASS_EN
        o_iss_a       = a_rdy[k] ? a_val[k] : i_cdb_data;
        o_iss_b       = b_rdy[k] ? b_val[k] : i_cdb_data;
`else
        o_iss_a       = a_val[k];
        o_iss_b       = b_val[k];
`endif
      end
    end
  end

  // new entry's row records every current entry as older; its column is cleared everywhere else
  always_comb begin
    for (int r = 0; r < DEPTH; r++)
      for (int c = 0; c < DEPTH; c++)
        age_nxt[r][c] = (accept && free_oh[r]) ? valid[c] :
                        (accept && free_oh[c]) ? 1'b0 : age[r][c];
  end

  // occupancy, valid bits and age order; flush wins over dispatch and issue
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid <= '0;
      age   <= '0;
      count <= '0;
    end else if (i_flush) begin
      valid <= '0;
      count <= '0;
    end else begin
      valid <= (valid & ~(fire ? grant : '0)) | (accept ? free_oh : '0);
      age   <= age_nxt;
      count <= count + CNT_W'(accept) - CNT_W'(fire);
    end
  end

  // entry payload: write on dispatch with same-cycle CDB capture, otherwise wake up on tag match
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < DEPTH; k++) begin
      if (accept && free_oh[k]) begin
        ctrl[k]    <= i_disp_ctrl;
        dst_tag[k] <= i_disp_dst_tag;
        a_tag[k]   <= i_disp_a_tag;
        b_tag[k]   <= i_disp_b_tag;
        a_rdy[k]   <= i_disp_a_rdy || disp_a_hit;
        b_rdy[k]   <= i_disp_b_rdy || disp_b_hit;
        a_val[k]   <= i_disp_a_rdy ? i_disp_a_val : i_cdb_data;
        b_val[k]   <= i_disp_b_rdy ? i_disp_b_val : i_cdb_data;
      end else begin
        if (valid[k] && !a_rdy[k] && a_hit[k]) begin
          a_rdy[k] <= 1'b1;
          a_val[k] <= i_cdb_data;
        end
        if (valid[k] && !b_rdy[k] && b_hit[k]) begin
          b_rdy[k] <= 1'b1;
          b_val[k] <= i_cdb_data;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_rsv_station.sv
// tb_alu_rsv_station: directed stimulus, queue-based age-ordered model checked every cycle, plus literal spot checks
module tb_alu_rsv_station;
  import alu_rsv_station_pkg::*;
  localparam int DEPTH = 4;

  logic        clk = 0, rst_n = 0, flush = 0;
  logic        disp_valid = 0, disp_ready;
  logic [1:0]  disp_ctrl = 0;
  logic [3:0]  disp_dst = 0, disp_at = 0, disp_bt = 0;
  logic        disp_ar = 0, disp_br = 0;
  logic [31:0] disp_av = 0, disp_bv = 0;
  logic        cdb_valid = 0;
  logic [3:0]  cdb_tag = 0;
  logic [31:0] cdb_data = 0;
  logic        iss_valid, iss_ready = 0;
  logic [1:0]  iss_ctrl;
  logic [31:0] iss_a, iss_b;
  logic [3:0]  iss_dst;
  logic [2:0]  count;
  int          checks = 0, errors = 0;

  alu_rsv_station dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_disp_valid(disp_valid), .o_disp_ready(disp_ready), .i_disp_ctrl(disp_ctrl),
    .i_disp_dst_tag(disp_dst), .i_disp_a_rdy(disp_ar), .i_disp_b_rdy(disp_br),
    .i_disp_a_val(disp_av), .i_disp_b_val(disp_bv), .i_disp_a_tag(disp_at), .i_disp_b_tag(disp_bt),
    .i_cdb_valid(cdb_valid), .i_cdb_tag(cdb_tag), .i_cdb_data(cdb_data),
    .o_iss_valid(iss_valid), .i_iss_ready(iss_ready), .o_iss_ctrl(iss_ctrl),
    .o_iss_a(iss_a), .o_iss_b(iss_b), .o_iss_dst_tag(iss_dst), .o_count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  c;
    logic [3:0]  d, at, bt;
    logic        ar, br;
    logic [31:0] av, bv;
  } ent_t;
  ent_t q[$];

  function automatic bit hit(input logic [3:0] t);
    return cdb_valid && t == cdb_tag;
  endfunction

  function automatic bit ok(input logic r, input logic [3:0] t);
`ifdef ALU_RS_WAKEUP_BYPASS_EN
    return r || hit(t);
`else
    return r;
`endif
  endfunction

  function automatic int sel();
    foreach (q[i]) if (ok(q[i].ar, q[i].at) && ok(q[i].br, q[i].bt)) return i;
    return -1;
  endfunction

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge rst_n) q.delete();

  always @(posedge clk) if (rst_n) begin
    int s, n;
    ent_t e;
    s = sel();
    n = q.size();
    if (flush) q.delete();
    else begin
      foreach (q[i]) begin
        if (!q[i].ar && hit(q[i].at)) begin q[i].ar = 1; q[i].av = cdb_data; end
        if (!q[i].br && hit(q[i].bt)) begin q[i].br = 1; q[i].bv = cdb_data; end
      end
      if (s >= 0 && iss_ready) q.delete(s);
      if (disp_valid && n < DEPTH) begin
        e.c = disp_ctrl; e.d = disp_dst; e.at = disp_at; e.bt = disp_bt;
        e.ar = disp_ar || hit(disp_at); e.av = disp_ar ? disp_av : cdb_data;
        e.br = disp_br || hit(disp_bt); e.bv = disp_br ? disp_bv : cdb_data;
        q.push_back(e);
      end
    end
  end

  always @(negedge clk) if (rst_n) begin
    int s;
    s = sel();
    chk("count", count, q.size());
    chk("disp_ready", disp_ready, q.size() < DEPTH);
    chk("iss_valid", iss_valid, s >= 0);
    if (s >= 0) begin
      chk("iss_ctrl", iss_ctrl, q[s].c);
      chk("iss_dst", iss_dst, q[s].d);
      chk("iss_a", iss_a, q[s].ar ? q[s].av : cdb_data);
      chk("iss_b", iss_b, q[s].br ? q[s].bv : cdb_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [1:0] c, input logic [3:0] d, input logic ar, input logic [31:0] av,
                      input logic [3:0] at, input logic br, input logic [31:0] bv, input logic [3:0] bt);
    disp_valid = 1; disp_ctrl = c; disp_dst = d;
    disp_ar = ar; disp_av = av; disp_at = at;
    disp_br = br; disp_bv = bv; disp_bt = bt;
    tick();
    disp_valid = 0;
  endtask

  task automatic bcast(input logic [3:0] t, input logic [31:0] v);
    cdb_valid = 1; cdb_tag = t; cdb_data = v;
    #1;
  endtask

  initial begin
    #2;
    chk("rst_count", count, 0);
    chk("rst_disp_ready", disp_ready, 1);
    chk("rst_iss_valid", iss_valid, 0);
    tick();
    rst_n = 1;
    tick();
    // ADD 5+7, dst 3
    disp(ALU_ADD, 3, 1, 5, 0, 1, 7, 0);
    #1;
    chk("t1_valid", iss_valid, 1);
    chk("t1_ctrl", iss_ctrl, 2'b00);
    chk("t1_a", iss_a, 5);
    chk("t1_b", iss_b, 7);
    chk("t1_dst", iss_dst, 3);
    iss_ready = 1; tick(); iss_ready = 0;
    chk("t1_count", count, 0);
    // SUB waiting on tag 9
    disp(ALU_SUB, 5, 0, 0, 9, 1, 3, 0);
    chk("t2_wait", iss_valid, 0);
    tick();
    bcast(9, 32'h10);
`ifdef ALU_RS_WAKEUP_BYPASS_EN
    chk("t2_bypass_valid", iss_valid, 1);
    chk("t2_bypass_a", iss_a, 32'h10);
`else
    chk("t2_nobypass_valid", iss_valid, 0);
`endif
    tick();
    cdb_valid = 0;
    #1;
    chk("t2_valid", iss_valid, 1);
    chk("t2_a", iss_a, 32'h10);
    chk("t2_b", iss_b, 3);
    chk("t2_ctrl", iss_ctrl, 2'b01);
    iss_ready = 1; tick(); iss_ready = 0;
    // capture in dispatch cycle
    bcast(4, 32'hFF);
    disp(ALU_PASSB, 6, 0, 0, 4, 1, 32'h22, 0);
    cdb_valid = 0;
    #1;
    chk("t3_valid", iss_valid, 1);
    chk("t3_a", iss_a, 32'hFF);
    chk("t3_dst", iss_dst, 6);
    iss_ready = 1; tick(); iss_ready = 0;
    // fill, refused dispatch while full even with issue, then in-order drain
    for (int i = 0; i < 4; i++) disp(2'(i), 4'(i), 1, 32'(i + 1), 0, 1, 32'(i + 10), 0);
    chk("t4_count", count, 4);
    chk("t4_disp_ready", disp_ready, 0);
    disp_valid = 1; disp_dst = 4'hF; iss_ready = 1;
    #1;
    chk("t4_order0", iss_dst, 0);
    tick();
    disp_valid = 0;
    chk("t4_refused_count", count, 3);
    for (int i = 1; i < 4; i++) begin
      chk("t4_order", iss_dst, 4'(i));
      tick();
    end
    iss_ready = 0;
    chk("t4_empty", count, 0);
    // older waits on tag 2, younger on tag 1
    disp(ALU_ADD, 10, 0, 0, 2, 1, 1, 0);
    disp(ALU_ADD, 11, 0, 0, 1, 1, 2, 0);
    bcast(1, 32'hA1);
    tick();
    cdb_valid = 0;
    #1;
    chk("t5_young_first", iss_dst, 11);
    bcast(2, 32'hA2);
    tick();
    cdb_valid = 0;
    #1;
    chk("t5_old_wins", iss_dst, 10);
    chk("t5_old_a", iss_a, 32'hA2);
    iss_ready = 1; tick();
    chk("t5_then_young", iss_dst, 11);
    tick(); iss_ready = 0;
    // flush with simultaneous dispatch
    for (int i = 0; i < 3; i++) disp(ALU_PASSA, 4'(i + 1), 1, 32'(i), 0, 1, 0, 0);
    chk("t6_count", count, 3);
    flush = 1;
    disp(ALU_ADD, 7, 1, 1, 0, 1, 1, 0);
    flush = 0;
    chk("t6_flush_count", count, 0);
    chk("t6_flush_valid", iss_valid, 0);
    // async reset mid-stream
    disp(ALU_ADD, 1, 1, 9, 0, 1, 9, 0);
    disp(ALU_SUB, 2, 1, 8, 0, 1, 8, 0);
    #2;
    rst_n = 0;
    #1;
    chk("t7_count", count, 0);
    chk("t7_valid", iss_valid, 0);
    chk("t7_disp_ready", disp_ready, 1);
    chk("t7_iss_a", iss_a, 0);
    tick();
    rst_n = 1;
    tick();
    chk("t7_after", count, 0);
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
